mdu_seq: RTL and testbench



---
 rtl/mdu_seq.sv | 135 +++++++++++++
 tb/tb_mdu_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide unit with HI/LO registers
// Define MDU_MADD_EN to enable MADD/MADDU (ops 6/7); otherwise they are ignored.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic             is_mul, is_div;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0] abs_a, abs_b, uq, ur;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_we;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Signed results come from magnitudes so MIN_INT / -1 wraps naturally to MIN_INT, rem 0.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    abs_a  = (op_q == OP_DIV && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b  = (op_q == OP_DIV && b_q[WIDTH-1]) ? -b_q : b_q;
    uq     = '0;
    ur     = '0;
    if (b_q != '0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
  end

  always_comb begin
    res_we = 1'b0;
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT:  begin res_we = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin res_we = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        res_we = (b_q != '0);
        res_lo = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -uq : uq;
        res_hi = a_q[WIDTH-1] ? -ur : ur;
      end
      OP_DIVU: begin
        res_we = (b_q != '0);
        res_lo = uq;
        res_hi = ur;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res_we = 1'b1; {res_hi, res_lo} = {hi, lo} + prod_s; end
      OP_MADDU: begin res_we = 1'b1; {res_hi, res_lo} = {hi, lo} + prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              op_q  <= op;
              a_q   <= a;
              b_q   <= b;
              cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against an arithmetic model
// Model honours MDU_MADD_EN the same way the design build does.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hm = '0, lm = '0;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  mdu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inj_kind: 0 none, 1 stray MTLO start, 2 reset; applied during busy cycle inj_cyc
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inj_cyc, input int inj_kind);
    int lat;
    longint ps;
    logic [63:0] pu, acc;
    logic [31:0] nh, nl;
    int sx, sy;
    lat = 0; nh = hm; nl = lm;
    ps  = longint'($signed(x)) * longint'($signed(y));
    pu  = {32'b0, x} * {32'b0, y};
    sx  = $signed(x); sy = $signed(y);
    case (o)
      4'd0: begin lat = 5; {nh, nl} = ps; end
      4'd1: begin lat = 5; {nh, nl} = pu; end
      4'd2: begin
        lat = 10;
        if (sy != 0) begin
          if (sx == 32'sh8000_0000 && sy == -1) begin nl = 32'h8000_0000; nh = 0; end
          else begin nl = sx / sy; nh = sx % sy; end
        end
      end
      4'd3: begin lat = 10; if (y != 0) begin nl = x / y; nh = x % y; end end
      4'd4: nh = x;
      4'd5: nl = x;
      4'd6: if (MADD_EN) begin lat = 5; acc = {hm, lm} + ps; {nh, nl} = acc; end
      4'd7: if (MADD_EN) begin lat = 5; acc = {hm, lm} + pu; {nh, nl} = acc; end
      default: ;
    endcase
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < lat; i++) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("hi_hold", hi, hm);
      chk("lo_hold", lo, lm);
      if (i + 1 == inj_cyc && inj_kind == 1) begin
        start = 1'b1; op = 4'd5; a = 32'h5;
      end
      if (i + 1 == inj_cyc && inj_kind == 2) reset = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        hm = '0; lm = '0;
        chk("busy_rst", {31'b0, busy}, 32'd0);
        chk("hi_rst", hi, 32'd0);
        chk("lo_rst", lo, 32'd0);
        return;
      end
    end
    hm = nh; lm = nl;
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("hi_done", hi, hm);
    chk("lo_done", lo, lm);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("busy_reset", {31'b0, busy}, 32'd0);
    chk("hi_reset", hi, 32'd0);
    chk("lo_reset", lo, 32'd0);

    do_op(4'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFA);
    do_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("divu_lo_const", lo, 32'h7FFF_FFFC);
    chk("divu_hi_const", hi, 32'd1);
    do_op(4'd4, 32'h11, 32'd0, 0, 0);
    do_op(4'd5, 32'h22, 32'd0, 0, 0);
    do_op(4'd2, 32'd1234, 32'd0, 0, 0);
    chk("div0_hi_const", hi, 32'h11);
    chk("div0_lo_const", lo, 32'h22);
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("minint_lo_const", lo, 32'h8000_0000);
    chk("minint_hi_const", hi, 32'd0);
    do_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1);
    chk("multu_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_lo_const", lo, 32'h0000_0001);
    do_op(4'd2, 32'd100, 32'd7, 4, 2);
    do_op(4'd0, 32'd6, 32'd7, 0, 0);
    chk("after_rst_lo", lo, 32'd42);
    chk("after_rst_hi", hi, 32'd0);
    do_op(4'd4, 32'h0, 32'd0, 0, 0);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd0, 0, 0);
    do_op(4'd7, 32'd1, 32'd1, 0, 0);
    do_op(4'd9, 32'h1234, 32'h5, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 9));
      do_op(ro, pick(), pick(), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
